// File: rtl/sipo_pkg.sv
// Shared types and helpers for the framed serial-in/parallel-out deserializer.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of an index over n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial shift register for one word. o_word is the value the register holds
// after the current edge, so a word can be captured on its final bit.
module sipo_shift_core #(
    parameter int WIDTH     = 24,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_word
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_base = i_clear ? '0 : r_sr;
        w_next = w_base;
        if (i_shift) begin
            // LSB-first streams enter at the top so the first bit ends at bit 0.
            if (MSB_FIRST) begin
                w_next = {w_base[WIDTH-2:0], i_bit};
            end else begin
                w_next = {i_bit, w_base[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_next;
        end
    end

    assign o_word = w_next;

endmodule

// File: rtl/sipo_frame_deserializer.sv
// Framed SIPO deserializer: CHANNELS words of WIDTH bits per frame_sync-aligned
// frame, delivered through a valid/ready holding register.
// Optional per-word even parity bit: define SIPO_FRAME_PARITY_EN.
//
//   state | meaning
//   IDLE  | waiting for frame_sync to start channel 0
//   SHIFT | collecting bits of the current word within a frame
module sipo_frame_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int CHANNELS  = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                enable,
    input  logic                                in,
    input  logic                                frame_sync,
    output logic [WIDTH-1:0]                    out,
    output logic [clog2_min1(CHANNELS)-1:0]     out_channel,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                overrun,
    output logic                                frame_err,
    output logic                                parity_err,
    input  logic                                clear_err
);

    localparam int CHW = clog2_min1(CHANNELS);
    localparam int BCW = $clog2(WIDTH + 2);
`ifdef SIPO_FRAME_PARITY_EN
    localparam int WORD_BITS = WIDTH + 1;
`else
    localparam int WORD_BITS = WIDTH;
`endif
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_BITS - 1);
    localparam logic [CHW-1:0] LAST_CH  = CHW'(CHANNELS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [BCW-1:0]   r_bit_cnt;
    logic [BCW-1:0]   w_bit_cnt_next;
    logic [CHW-1:0]   r_ch_cnt;
    logic [CHW-1:0]   w_ch_cnt_next;
    logic             w_take;
    logic             w_clear;
    logic             w_resync;
    logic             w_complete;
    logic             w_shift;
    logic [WIDTH-1:0] w_word;

    logic [WIDTH-1:0] r_out;
    logic [CHW-1:0]   r_out_ch;
    logic             r_valid;
    logic             r_overrun;
    logic             r_frame_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_ch_cnt  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_ch_cnt  <= w_ch_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_ch_cnt_next  = r_ch_cnt;
        w_take         = 1'b0;
        w_clear        = 1'b0;
        w_resync       = 1'b0;
        w_complete     = 1'b0;
        if (enable) begin
            case (r_state)
                IDLE: begin
                    if (frame_sync) begin
                        w_take         = 1'b1;
                        w_clear        = 1'b1;
                        w_bit_cnt_next = BCW'(1);
                        w_ch_cnt_next  = '0;
                        w_state_next   = SHIFT;
                    end
                end
                SHIFT: begin
                    w_take = 1'b1;
                    if (frame_sync) begin
                        // Mid-frame sync: discard the partial word and restart at channel 0.
                        w_clear        = 1'b1;
                        w_resync       = 1'b1;
                        w_bit_cnt_next = BCW'(1);
                        w_ch_cnt_next  = '0;
                    end else if (r_bit_cnt == LAST_BIT) begin
                        w_complete     = 1'b1;
                        w_bit_cnt_next = '0;
                        if (r_ch_cnt == LAST_CH) begin
                            w_ch_cnt_next = '0;
                            w_state_next  = IDLE;
                        end else begin
                            w_ch_cnt_next = r_ch_cnt + 1'b1;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

`ifdef SIPO_FRAME_PARITY_EN
    // The trailing parity bit is checked but never shifted into the word.
    assign w_shift = w_take && (w_clear || (r_bit_cnt != LAST_BIT));
`else
    assign w_shift = w_take;
`endif

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_core (
        .clk     (clk),
        .rstn    (rstn),
        .i_clear (w_clear),
        .i_shift (w_shift),
        .i_bit   (in),
        .o_word  (w_word)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out       <= '0;
            r_out_ch    <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_complete) begin
                r_out    <= w_word;
                r_out_ch <= r_ch_cnt;
                r_valid  <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            r_overrun   <= (w_complete && r_valid && !out_ready) || (r_overrun && !clear_err);
            r_frame_err <= w_resync || (r_frame_err && !clear_err);
        end
    end

`ifdef SIPO_FRAME_PARITY_EN
    logic r_parity_err;
    logic w_parity_bad;

    assign w_parity_bad = w_complete && ((^w_word) ^ in);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_parity_bad || (r_parity_err && !clear_err);
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign out         = r_out;
    assign out_channel = r_out_ch;
    assign out_valid   = r_valid;
    assign overrun     = r_overrun;
    assign frame_err   = r_frame_err;

endmodule

// File: doc/sipo_frame_deserializer.md
Name: sipo_frame_deserializer

Overview:
- Parametrised serial-in/parallel-out deserializer for framed audio bitstreams, such as multi-slot I2S- or TDM-style links.
- Assembles CHANNELS words of WIDTH bits per frame, aligned to a frame_sync strobe, in LSB-first or MSB-first order.
- Each completed word goes out on a valid/ready holding register, tagged with its channel index.
- Sits between the serial ADC/codec pin interface and the sample-processing pipeline, replacing fixed-width free-running shift registers.

Parameters:
- WIDTH, 24: data bits per word (2..64).
- CHANNELS, 2: words per frame (1..16).
- MSB_FIRST, 0: 0 = LSB arrives first; 1 = MSB arrives first.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- enable  in  1  bit strobe; in and frame_sync are sampled only when high.
- in  in  1  serial data bit.
- frame_sync  in  1  marks the current bit as bit 0 of channel 0.
- out  out  WIDTH  assembled word, bit-ordered with word bit 0 = LSB.
- out_channel  out  max(1,$clog2(CHANNELS))  channel index of out.
- out_valid  out  1  holding register contains an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- overrun  out  1  sticky: an unconsumed word was overwritten.
- frame_err  out  1  sticky: frame_sync arrived mid-frame.
- parity_err  out  1  sticky parity mismatch; tied 0 without the optional feature.
- clear_err  in  1  synchronous clear of all sticky flags.

Behaviour:
- Reset (async, rstn low): state IDLE, all counters 0, shift reg 0; out=0, out_channel=0, out_valid=0, overrun=0, frame_err=0, parity_err=0. A partial word is discarded.
- enable low: all state holds. Handshake and clear_err still act every cycle.
- FSM states:
  - IDLE: enable && frame_sync -> shift the bit in, bit_cnt=1, ch_cnt=0, go to SHIFT. enable without frame_sync -> bit ignored.
  - SHIFT, enable && !frame_sync: shift the bit in and increment bit_cnt.
    - When the bit sampled is the last bit of the word: load the holding register, set bit_cnt=0, increment ch_cnt.
    - If that word was channel CHANNELS-1: go to IDLE, ch_cnt=0.
  - SHIFT, enable && frame_sync: set frame_err, drop the partial word, treat the bit as bit 0 of channel 0 (resync), stay in SHIFT.
    - Exception: frame_sync on the first bit after the final word of a frame is normal (FSM already in IDLE).
- Shift direction:
  - MSB_FIRST=0: new bit enters at MSB, register shifts right.
  - MSB_FIRST=1: new bit enters at LSB, register shifts left.
  - After WIDTH bits, out bit 0 is always the numeric LSB.
- Latency: out/out_valid update on the same clk edge that samples the final bit; visible the following cycle.
- Holding register and handshake:
  - Completion with out_valid=0: load; out_valid=1.
  - Completion with out_valid && out_ready in the same cycle: old word consumed, new word loaded, out_valid stays 1, no overrun.
  - Completion with out_valid && !out_ready: new word overwrites (newest wins), overrun=1.
  - No completion and out_valid && out_ready: out_valid=0. out and out_channel hold their last value.
- clear_err: clears sticky flags. A flag-setting event in the same cycle wins (flag stays 1).
- Counters: bit_cnt is $clog2(WIDTH+2) bits; ch_cnt is max(1,$clog2(CHANNELS)) bits. Neither wraps past its terminal value.

Optional Feature:
- Macro: SIPO_FRAME_PARITY_EN.
- Defined:
  - Each word is WIDTH data bits followed by one even-parity bit; completion happens on the parity bit.
  - If XOR(data) ^ parity_bit = 1: parity_err=1. The word is still delivered.
  - The parity bit is never stored in out.
- Undefined: words are exactly WIDTH bits; parity_err is a constant 0.

Decomposition:
- Package sipo_pkg: state enum (IDLE, SHIFT) and a clog2-min-1 helper function.
- One sub-module, sipo_shift_core, parameters WIDTH and MSB_FIRST: shift register with clear and shift-enable, exposing the parallel word.
- FSM, counters, holding register and flags live in the top module.

Test Plan:
- WIDTH=16, CHANNELS=2, MSB_FIRST=0: frame_sync on the first bit, send 0x1234 then 0xABCD LSB-first -> out=0x1234/ch0, then 0xABCD/ch1; out_ready held high; each out_valid a one-cycle pulse; FSM back in IDLE.
- Same stream with MSB_FIRST=1, bits sent MSB-first -> identical out values; frame_err=0.
- out_ready=0 throughout a two-word frame -> out=0xABCD, out_channel=1, overrun=1. Pulse clear_err -> overrun=0.
- frame_sync asserted at bit 7 of channel 0, then a full clean frame (0x00FF, 0xFF00) -> frame_err=1; partial word never appears on out; the clean words follow.
- Pull rstn low mid-word at bit 9 (asynchronous, between edges) -> out_valid=0 immediately. After release, a new frame (0x5A5A, 0xA5A5) decodes correctly.
- With SIPO_FRAME_PARITY_EN, 17-bit words: 0x0003 with parity 0 -> parity_err stays 0. 0x0001 with parity 0 -> parity_err=1 and out=0x0001 still delivered.
